// File: rtl/ex_mem_pkg.sv
// Shared types for the EX/MEM pipeline register: payload layout, control bits,
// skid-buffer states and the ALU control encodings used by execute.
package ex_mem_pkg;

    localparam int EX_MEM_DATA_W = 64;
    localparam int EX_MEM_REG_AW = 5;
    localparam int CTRL_W        = 5;

    localparam int CTRL_BRANCH     = 4;
    localparam int CTRL_MEM_READ   = 3;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_REG_WRITE  = 1;
    localparam int CTRL_MEM_TO_REG = 0;

    typedef struct packed {
        logic branch;
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
    } ctrl_t;

    typedef struct packed {
        logic [EX_MEM_DATA_W-1:0] alu_result;
        logic                     zero;
        logic [EX_MEM_DATA_W-1:0] write_data;
        logic [EX_MEM_DATA_W-1:0] pc_branch;
        logic [EX_MEM_REG_AW-1:0] rd;
        ctrl_t                    ctrl;
    } ex_mem_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

    typedef enum logic [3:0] {
        ALU_AND    = 4'b0000,
        ALU_ORR    = 4'b0001,
        ALU_ADD    = 4'b0010,
        ALU_SUB    = 4'b0110,
        ALU_PASS_B = 4'b0111
    } alu_ctrl_t;

    // A bubble must never carry a stray RegWrite/MemWrite downstream.
    function automatic ctrl_t ctrl_mask(input ctrl_t c, input logic valid);
        ctrl_t r;
        if (valid) begin
            r = c;
        end else begin
            r = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/ex_mem_stage_pipe_skid.sv
// Generic valid/ready pipeline register. Single entry by default; defining
// EX_MEM_SKID_EN builds a two-entry skid buffer with a registered in_ready.
module pipe_skid
    import ex_mem_pkg::*;
#(
    parameter type T = logic [7:0]
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

`ifdef EX_MEM_SKID_EN
    skid_state_t state_r;
    skid_state_t state_next;
    T            main_r;
    T            skid_r;
    logic        in_ready_s;
    logic        out_valid_s;
    logic        in_fire;
    logic        out_fire;

    assign in_fire   = in_valid && in_ready_s;
    assign out_fire  = out_valid_s && out_ready;
    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_data  = main_r;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_r <= SKID_EMPTY;
        end else begin
            state_r <= state_next;
        end
    end

    always_comb begin
        state_next = state_r;
        case (state_r)
            SKID_EMPTY: state_next = in_fire ? SKID_ONE : SKID_EMPTY;
            SKID_ONE: begin
                if (in_fire && !out_fire) begin
                    state_next = SKID_FULL;
                end else if (out_fire && !in_fire) begin
                    state_next = SKID_EMPTY;
                end else begin
                    state_next = SKID_ONE;
                end
            end
            SKID_FULL:  state_next = out_fire ? SKID_ONE : SKID_FULL;
            default:    state_next = SKID_EMPTY;
        endcase
    end

    // Handshake outputs decode the state register only, so in_ready never sees out_ready.
    always_comb begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
        case (state_r)
            SKID_EMPTY: begin in_ready_s = 1'b1; out_valid_s = 1'b0; end
            SKID_ONE:   begin in_ready_s = 1'b1; out_valid_s = 1'b1; end
            SKID_FULL:  begin in_ready_s = 1'b0; out_valid_s = 1'b1; end
            default:    begin in_ready_s = 1'b1; out_valid_s = 1'b0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_r <= '0;
            skid_r <= '0;
        end else if (!flush) begin
            case (state_r)
                SKID_EMPTY: if (in_fire) main_r <= in_data;
                SKID_ONE: begin
                    if (in_fire && out_fire) begin
                        main_r <= in_data;
                    end else if (in_fire) begin
                        skid_r <= in_data;
                    end
                end
                SKID_FULL:  if (out_fire) main_r <= skid_r;
                default:    main_r <= main_r;
            endcase
        end
    end
`else
    logic valid_r;
    T     data_r;

    assign in_ready  = !valid_r || out_ready;
    assign out_valid = valid_r;
    assign out_data  = data_r;

    // Load wins over drain so a simultaneous transfer replaces the old bundle.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (in_valid && in_ready) begin
            valid_r <= 1'b1;
            data_r  <= in_data;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register for the LEGv8 datapath: wraps pipe_skid and masks
// control on bubbles. Define EX_MEM_SKID_EN for the two-entry skid variant.
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic              in_zero,
    input  logic [DATA_W-1:0] in_write_data,
    input  logic [DATA_W-1:0] in_pc_branch,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [4:0]        in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu_result,
    output logic              out_zero,
    output logic [DATA_W-1:0] out_write_data,
    output logic [DATA_W-1:0] out_pc_branch,
    output logic [REG_AW-1:0] out_rd,
    output logic [4:0]        out_ctrl
);

    typedef struct packed {
        logic [DATA_W-1:0] alu_result;
        logic              zero;
        logic [DATA_W-1:0] write_data;
        logic [DATA_W-1:0] pc_branch;
        logic [REG_AW-1:0] rd;
        ctrl_t             ctrl;
    } payload_t;

    payload_t in_data;
    payload_t out_data;

    assign in_data.alu_result = in_alu_result;
    assign in_data.zero       = in_zero;
    assign in_data.write_data = in_write_data;
    assign in_data.pc_branch  = in_pc_branch;
    assign in_data.rd         = in_rd;
    assign in_data.ctrl       = in_ctrl;

    pipe_skid #(.T(payload_t)) u_pipe (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    assign out_alu_result = out_data.alu_result;
    assign out_zero       = out_data.zero;
    assign out_write_data = out_data.write_data;
    assign out_pc_branch  = out_data.pc_branch;
    assign out_rd         = out_data.rd;
    assign out_ctrl       = ctrl_mask(out_data.ctrl, out_valid);

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

EX/MEM pipeline register for the LEGv8 pipelined datapath. Captures the execute-stage outputs: ALU result, zero flag, store data, branch target, destination register and MEM/WB control. Presents them to the memory stage behind a valid/ready handshake. Supports back-pressure (data-memory wait states) and flush on taken-branch redirect.

## Interface
- `DATA_W`, default 64: width of result, store data and branch target.
- `REG_AW`, default 5: register-address width.
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `flush`  in  1: discard all held entries and any input transfer this cycle.
- `in_valid`  in  1: execute stage presents a valid bundle.
- `in_ready`  out  1: stage accepts a bundle this cycle.
- `in_alu_result`  in  DATA_W: ALU result.
- `in_zero`  in  1: ALU zero flag.
- `in_write_data`  in  DATA_W: store data (rt operand).
- `in_pc_branch`  in  DATA_W: computed branch target.
- `in_rd`  in  REG_AW: destination register.
- `in_ctrl`  in  5: {Branch, MemRead, MemWrite, RegWrite, MemtoReg}.
- `out_valid`  out  1: held bundle valid toward MEM.
- `out_ready`  in  1: MEM consumes the bundle this cycle.
- `out_alu_result`, `out_zero`, `out_write_data`, `out_pc_branch`, `out_rd`, `out_ctrl`  out: registered copies of the input fields, same widths.

## Operation
- Input transfer occurs when `in_valid && in_ready`. Output transfer occurs when `out_valid && out_ready`.
- Payload is stored unmodified. No arithmetic. `out_zero` is the captured flag and is never recomputed.
- Priority on each edge: `reset` > `flush` > transfers.
- Reset or flush: all entries are invalidated. `out_valid`=0 on the next cycle. An input offered in the same cycle is dropped.
- Reset values: `out_valid`=0, `out_ctrl`=0 (no stray RegWrite/MemWrite), all data outputs=0. After reset, `in_ready`=1.
- Entries are released in order and never duplicated or lost, except on flush.
- Data outputs hold when `out_valid && !out_ready`.
- `out_ctrl` is forced to 0 whenever `out_valid`=0 (bubble insertion).
- Simultaneous input and output transfer on a full main entry: the old bundle leaves and the new bundle loads in the same edge.

## Timing
- Latency: bundle accepted at edge N appears on outputs after edge N, i.e. in cycle N+1.
- Throughput: 1 bundle/cycle while `out_ready`=1.
- Behaviour with `EX_MEM_SKID_EN` is given under Configuration.
- Without the macro:
  - `in_ready = !out_valid || out_ready` (combinational path from `out_ready`).
  - A single entry is stored.

## Configuration
- Macro `EX_MEM_SKID_EN` defined: two-entry skid buffer with states EMPTY, ONE and FULL.
  - `in_ready` = (state != FULL). It is a registered signal with no combinational dependence on `out_ready`.
  - EMPTY -> ONE on input transfer.
  - ONE -> FULL on input transfer without output transfer.
  - ONE -> EMPTY on output transfer without input transfer.
  - FULL -> ONE on output transfer; the skid entry moves into the main entry.
  - Any state -> EMPTY on flush or reset.
- Macro undefined: single-entry register as described under Timing. No skid storage is synthesised.

## Structure
- Package `ex_mem_pkg` holds:
  - `ex_mem_t` packed struct of the payload fields.
  - `ctrl_t` struct for the 5 control bits, plus localparam bit indices.
  - The skid-state enum.
  - The `ALUControl` encodings shared with execute: AND 0000, ORR 0001, ADD 0010, SUB 0110, PASS-B 0111.
- Sub-module `pipe_skid` provides a generic valid/ready register, parameterised on payload type, with the skid variant under the macro. `ex_mem_stage` wraps it and applies bubble masking of `out_ctrl`.

## Test plan
- Reset check: assert `reset` for 2 cycles with `in_valid`=1 and result 0xDEAD. Required response: `out_valid`=0, `out_ctrl`=0, `in_ready`=1 on the first cycle after release.
- Streaming: issue results 1, 2, 3 on consecutive cycles with `out_ready`=1. Required response: outputs show 1, 2, 3 in cycles N+1..N+3, each with zero=0; then `out_valid`=0.
- Zero propagation: issue SUB result 0 with zero=1 and ctrl Branch=1, branch target 0x40. Required response: next cycle `out_zero`=1, `out_pc_branch`=0x40.
- Back-pressure: hold `out_ready`=0 for 3 cycles while offering 0x10, 0x20, 0x30.
  - Skid build: `in_ready` drops after 2 accepts; 0x30 is held upstream.
  - Non-skid build: only 0x10 is accepted.
  - On release, the bundles drain in order with no loss.
- Flush: with 2 bundles held and `in_valid`=1 (0x99), assert `flush` for 1 cycle. Required response: `out_valid`=0 next cycle and 0x99 is never output.
- Simultaneous transfer: with one bundle held and `out_ready`=1, offer 0x55. Required response: old bundle consumed and 0x55 shown the next cycle.
